scope_trigger: RTL and testbench

SCOPE_TRIGGER -- requirements
Module: scope_trigger

---
 rtl/scope_trigger.sv | 109 ++++++++++
 tb/tb_scope_trigger.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/scope_trigger.sv
// Logic-analyser style trigger: decimates the sample stream, waits for a trigger,
// then streams post-trigger samples to a capture buffer and freezes it.
module scope_trigger #(
    parameter int N     = 8,
    parameter int NDIV  = 8,
    parameter int NPOST = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     din,
    input  logic             din_valid,
    input  logic             arm,
    input  logic [N-1:0]     trig_mask,
    input  logic [N-1:0]     trig_value,
    input  logic             trig_edge,
    input  logic             trig_force,
    input  logic [NDIV-1:0]  decim,
    input  logic [NPOST-1:0] post_count,
    output logic [N-1:0]     dout,
    output logic             dout_latch,
    output logic             freeze,
    output logic             armed,
    output logic             triggered,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        POST,
        DONE
    } state_t;

    state_t           state_q;
    logic [NDIV-1:0]  dcnt_q;
    logic [NDIV-1:0]  dcnt_d;
    logic [NPOST-1:0] pcnt_q;
    logic             prev_q;
    logic [N-1:0]     dout_q;
    logic             latch_q;
    logic             freeze_q;
    logic             keep;
    logic             match;
    logic             fire;

    assign keep   = din_valid && (dcnt_q == '0);
    assign dcnt_d = (dcnt_q >= decim) ? '0 : dcnt_q + NDIV'(1);
    assign match  = ((din & trig_mask) == (trig_value & trig_mask));
    // Edge mode fires only on a match that follows a kept non-matching sample.
    assign fire   = trig_force | (match & (~trig_edge | ~prev_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            dcnt_q   <= '0;
            pcnt_q   <= '0;
            prev_q   <= 1'b1;
            dout_q   <= '0;
            latch_q  <= 1'b0;
            freeze_q <= 1'b0;
        end else begin
            latch_q  <= 1'b0;
            freeze_q <= 1'b0;
            if (arm) begin
                state_q <= ARMED;
                dcnt_q  <= '0;
                prev_q  <= 1'b1;
            end else if (din_valid) begin
                dcnt_q <= dcnt_d;
                if (keep) begin
                    unique case (state_q)
                        ARMED: begin
                            dout_q  <= din;
                            latch_q <= 1'b1;
                            prev_q  <= match;
                            if (fire) begin
                                pcnt_q <= post_count;
                                if (post_count == '0) begin
                                    freeze_q <= 1'b1;
                                    state_q  <= DONE;
                                end else begin
                                    state_q <= POST;
                                end
                            end
                        end
                        POST: begin
                            dout_q  <= din;
                            latch_q <= 1'b1;
                            pcnt_q  <= pcnt_q - NPOST'(1);
                            if (pcnt_q == NPOST'(1)) begin
                                freeze_q <= 1'b1;
                                state_q  <= DONE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign dout       = dout_q;
    assign dout_latch = latch_q;
    assign freeze     = freeze_q;
    assign armed      = (state_q == ARMED);
    assign triggered  = (state_q == POST);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_scope_trigger.sv
// Directed bench for scope_trigger: expected latches are queued as samples are
// driven and checked against the strobe that follows one cycle later.
module tb_scope_trigger;

    logic       clk;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic       arm;
    logic [7:0] trig_mask;
    logic [7:0] trig_value;
    logic       trig_edge;
    logic       trig_force;
    logic [7:0] decim;
    logic [7:0] post_count;
    logic [7:0] dout;
    logic       dout_latch;
    logic       freeze;
    logic       armed;
    logic       triggered;
    logic       done;

    int         total = 0;
    int         bad = 0;
    string      tag = "init";
    logic [8:0] sb[$];

    scope_trigger #(.N(8), .NDIV(8), .NPOST(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .arm        (arm),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .trig_edge  (trig_edge),
        .trig_force (trig_force),
        .decim      (decim),
        .post_count (post_count),
        .dout       (dout),
        .dout_latch (dout_latch),
        .freeze     (freeze),
        .armed      (armed),
        .triggered  (triggered),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive inputs, queue the expected latch, then check the strobe.
    task automatic cyc(input logic [7:0] d, input logic v, input logic a,
                       input logic f, input logic el, input logic ef);
        logic [8:0] e;
        logic       xl;
        din        = d;
        din_valid  = v;
        arm        = a;
        trig_force = f;
        if (el) sb.push_back({ef, d});
        @(posedge clk);
        #1;
        xl = (sb.size() != 0);
        e  = 9'h0;
        if (xl) e = sb.pop_front();
        total++;
        assert ({dout_latch, freeze} === {xl, e[8]}) else begin
            bad++;
            $error("FAIL %s strobe: got latch=%0b freeze=%0b want latch=%0b freeze=%0b",
                   tag, dout_latch, freeze, xl, e[8]);
        end
        if (xl) begin
            total++;
            assert (dout === e[7:0]) else begin
                bad++;
                $error("FAIL %s dout: got %02h want %02h", tag, dout, e[7:0]);
            end
        end
    endtask

    task automatic chk_st(input logic a, input logic t, input logic d);
        total++;
        assert ({armed, triggered, done} === {a, t, d}) else begin
            bad++;
            $error("FAIL %s status: got a/t/d=%0b%0b%0b want %0b%0b%0b",
                   tag, armed, triggered, done, a, t, d);
        end
    endtask

    initial begin
        reset      = 1'b1;
        din        = 8'h00;
        din_valid  = 1'b0;
        arm        = 1'b0;
        trig_mask  = 8'hFF;
        trig_value = 8'h10;
        trig_edge  = 1'b0;
        trig_force = 1'b0;
        decim      = 8'd0;
        post_count = 8'd3;

        tag = "reset";
        cyc(8'h55, 1, 0, 0, 0, 0);
        cyc(8'h10, 1, 1, 0, 0, 0);
        total++;
        assert (dout === 8'h00) else begin
            bad++;
            $error("FAIL reset dout: got %02h want 00", dout);
        end
        chk_st(0, 0, 0);
        reset = 1'b0;

        tag = "idle_ignore";
        cyc(8'h10, 1, 0, 1, 0, 0);
        chk_st(0, 0, 0);

        tag = "level";
        cyc(8'h00, 0, 1, 0, 0, 0);
        chk_st(1, 0, 0);
        for (int i = 0; i <= 8'h13; i++)
            cyc(8'(i), 1, 0, 0, 1, i == 8'h13);
        chk_st(0, 0, 1);
        cyc(8'h14, 1, 0, 1, 0, 0);
        chk_st(0, 0, 1);

        tag = "edge";
        trig_edge = 1'b1;
        cyc(8'h10, 1, 0, 0, 0, 0);
        cyc(8'h10, 1, 1, 0, 0, 0);
        cyc(8'h10, 1, 0, 0, 1, 0);
        chk_st(1, 0, 0);
        cyc(8'h00, 1, 0, 0, 1, 0);
        chk_st(1, 0, 0);
        cyc(8'h10, 1, 0, 0, 1, 0);
        chk_st(0, 1, 0);
        cyc(8'h20, 1, 0, 0, 1, 0);
        cyc(8'h21, 1, 0, 0, 1, 0);
        cyc(8'h22, 1, 0, 0, 1, 1);
        chk_st(0, 0, 1);

        tag = "decim";
        trig_edge  = 1'b0;
        trig_value = 8'h0C;
        decim      = 8'd2;
        post_count = 8'd2;
        cyc(8'h00, 0, 1, 0, 0, 0);
        for (int i = 0; i <= 8'h16; i++)
            cyc(8'(i), 1, 0, 0, (i % 3 == 0) && (i <= 8'h12), i == 8'h12);
        chk_st(0, 0, 1);

        tag = "force_post0";
        decim      = 8'd0;
        post_count = 8'd0;
        trig_value = 8'hAA;
        cyc(8'h00, 0, 1, 0, 0, 0);
        cyc(8'h01, 1, 0, 0, 1, 0);
        chk_st(1, 0, 0);
        cyc(8'h02, 1, 0, 1, 1, 1);
        chk_st(0, 0, 1);
        cyc(8'h03, 1, 0, 1, 0, 0);

        tag = "reset_post";
        trig_value = 8'h10;
        post_count = 8'd3;
        cyc(8'h00, 0, 1, 0, 0, 0);
        cyc(8'h10, 1, 0, 0, 1, 0);
        cyc(8'h11, 1, 0, 0, 1, 0);
        chk_st(0, 1, 0);
        reset = 1'b1;
        #1;
        total++;
        assert ({dout, dout_latch, freeze} === 10'h0) else begin
            bad++;
            $error("FAIL reset_post async: got dout=%02h latch=%0b freeze=%0b want 0",
                   dout, dout_latch, freeze);
        end
        chk_st(0, 0, 0);
        cyc(8'h12, 1, 0, 0, 0, 0);
        reset = 1'b0;
        cyc(8'h10, 1, 0, 0, 0, 0);
        chk_st(0, 0, 0);
        cyc(8'h00, 0, 1, 0, 0, 0);
        cyc(8'h10, 1, 0, 0, 1, 0);
        cyc(8'h30, 1, 0, 0, 1, 0);
        cyc(8'h31, 1, 0, 0, 1, 0);
        cyc(8'h32, 1, 0, 0, 1, 1);
        chk_st(0, 0, 1);

        tag = "rearm_post";
        cyc(8'h00, 0, 1, 0, 0, 0);
        cyc(8'h10, 1, 0, 0, 1, 0);
        cyc(8'h40, 1, 0, 0, 1, 0);
        chk_st(0, 1, 0);
        cyc(8'h41, 1, 1, 0, 0, 0);
        chk_st(1, 0, 0);
        cyc(8'h05, 1, 0, 0, 1, 0);
        chk_st(1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
